// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: flow opcodes, FSM states
// and the conditional-branch decision helper.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_BR   = 3'd1,
    OP_BRZ  = 3'd2,
    OP_BRNZ = 3'd3,
    OP_JMP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } flow_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // Relative-branch decision: BR always, BRZ/BRNZ on the ALU zero flag.
  function automatic logic rel_taken(input flow_op_t op, input logic zero);
    logic taken;
    case (op)
      OP_BR:   taken = 1'b1;
      OP_BRZ:  taken = zero;
      OP_BRNZ: taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address stack: SD entries of D bits, occupancy counter sp
// in 0..SD. A push while full or pop while empty is ignored.
module ret_stack #(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [D-1:0]         push_data,
  output logic [D-1:0]         top_data,
  output logic [$clog2(SD):0]  sp,
  output logic                 full,
  output logic                 empty
);

  localparam int AW  = $clog2(SD);
  localparam int SPW = AW + 1;

  logic [D-1:0]   mem_r [SD];
  logic [SPW-1:0] sp_r;
  logic [AW-1:0]  wr_idx_s;
  logic [AW-1:0]  top_idx_s;
  logic           do_push_s;
  logic           do_pop_s;

  assign full      = (sp_r == SPW'(SD));
  assign empty     = (sp_r == SPW'(0));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty & ~push;
  // When sp==SD the low bits wrap to 0, so top_idx still lands on entry SD-1.
  assign wr_idx_s  = sp_r[AW-1:0];
  assign top_idx_s = sp_r[AW-1:0] - AW'(1);
  assign top_data  = mem_r[top_idx_s];
  assign sp        = sp_r;

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r <= SPW'(0);
    end else if (do_push_s) begin
      sp_r <= sp_r + SPW'(1);
    end else if (do_pop_s) begin
      sp_r <= sp_r - SPW'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Flow-control sequencer in front of the PC: run/halt FSM, Mealy jump decode,
// CALL/RET return stack and a saturating taken-jump counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D  = 12,
  parameter int SD = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 zero,
  input  logic [D-1:0]         offset,
  input  logic [D-1:0]         abs_tgt,
  input  logic [D-1:0]         prog_ctr,
  output logic                 reljump_en,
  output logic                 absjump_en,
  output logic [D-1:0]         target,
  output logic                 done,
  output logic                 stack_err,
  output logic [$clog2(SD):0]  sp,
  output logic [CW-1:0]        br_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  seq_state_t     state_r;
  seq_state_t     state_nxt_s;
  flow_op_t       op_s;
  logic           stack_err_r;
  logic [CW-1:0]  br_count_r;
  logic           push_s;
  logic           pop_s;
  logic           fault_s;
  logic           rel_s;
  logic           abs_s;
  logic [D-1:0]   target_s;
  logic           done_s;
  logic [D-1:0]   ret_addr_s;
  logic [D-1:0]   top_data_s;
  logic           full_s;
  logic           empty_s;

  assign op_s       = flow_op_t'(op);
  assign ret_addr_s = prog_ctr + D'(1);

  ret_stack #(
    .D  (D),
    .SD (SD)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (ret_addr_s),
    .top_data  (top_data_s),
    .sp        (sp),
    .full      (full_s),
    .empty     (empty_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and Mealy decode; idle/halt/fault paths all leave done=1.
  always_comb begin
    state_nxt_s = state_r;
    rel_s       = 1'b0;
    abs_s       = 1'b0;
    target_s    = D'(0);
    done_s      = 1'b1;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    fault_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        done_s = 1'b0;
        case (op_s)
          OP_NOP: begin
            done_s = 1'b0;
          end
          OP_BR, OP_BRZ, OP_BRNZ: begin
            if (rel_taken(op_s, zero)) begin
              rel_s    = 1'b1;
              target_s = offset;
            end else begin
              rel_s = 1'b0;
            end
          end
          OP_JMP: begin
            abs_s    = 1'b1;
            target_s = abs_tgt;
          end
          OP_CALL: begin
            if (full_s) begin
              fault_s     = 1'b1;
              done_s      = 1'b1;
              state_nxt_s = ST_HALT;
            end else begin
              push_s   = 1'b1;
              abs_s    = 1'b1;
              target_s = abs_tgt;
            end
          end
          OP_RET: begin
            if (empty_s) begin
              fault_s     = 1'b1;
              done_s      = 1'b1;
              state_nxt_s = ST_HALT;
            end else begin
              pop_s    = 1'b1;
              abs_s    = 1'b1;
              target_s = top_data_s;
            end
          end
          OP_HALT: begin
            done_s      = 1'b1;
            state_nxt_s = ST_HALT;
          end
          default: begin
            done_s = 1'b0;
          end
        endcase
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sticky stack fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_err_r <= 1'b0;
    end else if (fault_s) begin
      stack_err_r <= 1'b1;
    end else begin
      stack_err_r <= stack_err_r;
    end
  end

  // Saturating taken-jump counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_r <= CW'(0);
    end else if ((rel_s | abs_s) && (br_count_r != CNT_MAX)) begin
      br_count_r <= br_count_r + CW'(1);
    end else begin
      br_count_r <= br_count_r;
    end
  end

  assign reljump_en = rel_s;
  assign absjump_en = abs_s;
  assign target     = target_s;
  assign done       = done_s;
  assign stack_err  = stack_err_r;
  assign br_count   = br_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, plus hand sequences for the
// asynchronous reset during CALL and branch-counter saturation.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        zero;
  logic [11:0] offset;
  logic [11:0] abs_tgt;
  logic [11:0] prog_ctr;
  logic        reljump_en;
  logic        absjump_en;
  logic [11:0] target;
  logic        done;
  logic        stack_err;
  logic [2:0]  sp;
  logic [15:0] br_count;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic        z;
    logic [11:0] off;
    logic [11:0] abt;
    logic [11:0] pc;
    logic        rel;
    logic        abj;
    logic [11:0] tgt;
    logic        dn;
    logic        err;
    logic [2:0]  sp;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  pc_sequencer #(.D(12), .SD(4), .CW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .zero       (zero),
    .offset     (offset),
    .abs_tgt    (abs_tgt),
    .prog_ctr   (prog_ctr),
    .reljump_en (reljump_en),
    .absjump_en (absjump_en),
    .target     (target),
    .done       (done),
    .stack_err  (stack_err),
    .sp         (sp),
    .br_count   (br_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic [2:0] o, logic z, logic [11:0] off,
                              logic [11:0] abt, logic [11:0] pc, logic rel, logic abj,
                              logic [11:0] tgt, logic dn, logic err, logic [2:0] s,
                              logic [15:0] cnt);
    vec_t v;
    v.st = st; v.op = o; v.z = z; v.off = off; v.abt = abt; v.pc = pc;
    v.rel = rel; v.abj = abj; v.tgt = tgt; v.dn = dn; v.err = err; v.sp = s; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(int idx, logic rel, logic abj, logic [11:0] tgt, logic dn,
                            logic err, logic [2:0] s, logic [15:0] cnt);
    n_vec++;
    chk("reljump_en", idx, 32'(reljump_en), 32'(rel));
    chk("absjump_en", idx, 32'(absjump_en), 32'(abj));
    chk("target",     idx, 32'(target),     32'(tgt));
    chk("done",       idx, 32'(done),       32'(dn));
    chk("stack_err",  idx, 32'(stack_err),  32'(err));
    chk("sp",         idx, 32'(sp),         32'(s));
    chk("br_count",   idx, 32'(br_count),   32'(cnt));
  endtask

  task automatic drive(logic st, logic [2:0] o, logic z, logic [11:0] off,
                       logic [11:0] abt, logic [11:0] pc);
    start = st; op = o; zero = z; offset = off; abs_tgt = abt; prog_ctr = pc;
  endtask

  initial begin
    // Expected values are the outputs seen before the clock edge that consumes the row.
    vecs[0]  = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd0);
    vecs[1]  = mk(1'b1, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd0);
    vecs[2]  = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h001, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 16'd0);
    vecs[3]  = mk(1'b1, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h002, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 16'd0);
    vecs[4]  = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h003, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 16'd0);
    vecs[5]  = mk(1'b0, OP_BRZ,  1'b1, 12'hFFE, 12'h000, 12'h010, 1'b1, 1'b0, 12'hFFE, 1'b0, 1'b0, 3'd0, 16'd0);
    vecs[6]  = mk(1'b0, OP_BRZ,  1'b0, 12'hFFE, 12'h000, 12'h010, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 16'd1);
    vecs[7]  = mk(1'b0, OP_BRNZ, 1'b0, 12'h005, 12'h000, 12'h011, 1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 3'd0, 16'd1);
    vecs[8]  = mk(1'b0, OP_BR,   1'b1, 12'h123, 12'h000, 12'h016, 1'b1, 1'b0, 12'h123, 1'b0, 1'b0, 3'd0, 16'd2);
    vecs[9]  = mk(1'b0, OP_JMP,  1'b0, 12'h000, 12'h2AB, 12'h139, 1'b0, 1'b1, 12'h2AB, 1'b0, 1'b0, 3'd0, 16'd3);
    vecs[10] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h100, 12'h020, 1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 3'd0, 16'd4);
    vecs[11] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h200, 12'h105, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 3'd1, 16'd5);
    vecs[12] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h210, 1'b0, 1'b1, 12'h106, 1'b0, 1'b0, 3'd2, 16'd6);
    vecs[13] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h120, 1'b0, 1'b1, 12'h021, 1'b0, 1'b0, 3'd1, 16'd7);
    vecs[14] = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h021, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 16'd8);
    vecs[15] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h010, 12'hFFF, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 3'd0, 16'd8);
    vecs[16] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h018, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3'd1, 16'd9);
    vecs[17] = mk(1'b0, OP_HALT, 1'b0, 12'h000, 12'h000, 12'h033, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd10);
    vecs[18] = mk(1'b0, OP_JMP,  1'b0, 12'h000, 12'h3FF, 12'h033, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd10);
    vecs[19] = mk(1'b0, OP_JMP,  1'b0, 12'h000, 12'h3FF, 12'h033, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd10);
    vecs[20] = mk(1'b1, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd10);
    vecs[21] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h001, 12'h000, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 3'd0, 16'd10);
    vecs[22] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h002, 12'h001, 1'b0, 1'b1, 12'h002, 1'b0, 1'b0, 3'd1, 16'd11);
    vecs[23] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h003, 12'h002, 1'b0, 1'b1, 12'h003, 1'b0, 1'b0, 3'd2, 16'd12);
    vecs[24] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h004, 12'h003, 1'b0, 1'b1, 12'h004, 1'b0, 1'b0, 3'd3, 16'd13);
    vecs[25] = mk(1'b0, OP_CALL, 1'b0, 12'h000, 12'h005, 12'h004, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd4, 16'd14);
    vecs[26] = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h004, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 3'd4, 16'd14);
    vecs[27] = mk(1'b1, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h004, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 3'd4, 16'd14);
    vecs[28] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h005, 1'b0, 1'b1, 12'h004, 1'b0, 1'b1, 3'd4, 16'd14);
    vecs[29] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h004, 1'b0, 1'b1, 12'h003, 1'b0, 1'b1, 3'd3, 16'd15);
    vecs[30] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h003, 1'b0, 1'b1, 12'h002, 1'b0, 1'b1, 3'd2, 16'd16);
    vecs[31] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h002, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 3'd1, 16'd17);
    vecs[32] = mk(1'b0, OP_RET,  1'b0, 12'h000, 12'h000, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 3'd0, 16'd18);
    vecs[33] = mk(1'b0, OP_NOP,  1'b0, 12'h000, 12'h000, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 3'd0, 16'd18);

    reset = 1'b1;
    drive(1'b0, OP_NOP, 1'b0, 12'h000, 12'h000, 12'h000);
    @(negedge clk);
    #1;
    check_outs(100, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].op, vecs[i].z, vecs[i].off, vecs[i].abt, vecs[i].pc);
      #1;
      check_outs(i, vecs[i].rel, vecs[i].abj, vecs[i].tgt, vecs[i].dn,
                 vecs[i].err, vecs[i].sp, vecs[i].cnt);
    end

    // Reset asserted while a CALL is being presented: immediate return to reset values.
    @(negedge clk);
    drive(1'b1, OP_NOP, 1'b0, 12'h000, 12'h000, 12'h001);
    @(negedge clk);
    drive(1'b0, OP_CALL, 1'b0, 12'h000, 12'h080, 12'h040);
    #1;
    check_outs(200, 1'b0, 1'b1, 12'h080, 1'b0, 1'b1, 3'd0, 16'd18);
    #1;
    reset = 1'b1;
    #1;
    check_outs(201, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, OP_NOP, 1'b0, 12'h000, 12'h000, 12'h041);
    #1;
    check_outs(202, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 16'd0);

    // Hold BR until the counter saturates.
    @(negedge clk);
    drive(1'b1, OP_NOP, 1'b0, 12'h000, 12'h000, 12'h000);
    @(negedge clk);
    drive(1'b0, OP_BR, 1'b0, 12'h001, 12'h000, 12'h000);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    check_outs(300, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 3'd0, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_outs(301, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 3'd0, 16'hFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_outs(302, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 3'd0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
